// File: rtl/syn_sched_pkg.sv
// syn_sched_pkg: state encoding and default sweep geometry shared by syn_update_sched and syn_addr_gen.
// Optional build macro SYN_UPDATE_SKIP_ZERO_PRE_EN adds the PCHK (pre spike-count check) state.
package syn_sched_pkg;

    localparam int DEF_INPUT_NEURON       = 784;
    localparam int DEF_OUTPUT_NEURON      = 256;
    localparam int DEF_POST_NEUR_PARALLEL = 4;
    localparam int POST_WORDS             = DEF_OUTPUT_NEURON / DEF_POST_NEUR_PARALLEL;
    localparam int DEPTH                  = DEF_INPUT_NEURON * POST_WORDS;
    localparam int LAST_PRE               = DEF_INPUT_NEURON - 1;
    localparam int LAST_POST_WORD         = POST_WORDS - 1;

`ifdef SYN_UPDATE_SKIP_ZERO_PRE_EN
    typedef enum logic [1:0] {IDLE, RD, WR, PCHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
`endif

    // Counter width for an index range of n values, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/syn_addr_gen.sv
// syn_addr_gen: nested pre/post_word counters with a linear word-address counter kept in lockstep.
module syn_addr_gen
    import syn_sched_pkg::*;
#(
    parameter int N_PRE  = DEF_INPUT_NEURON,
    parameter int N_PW   = POST_WORDS,
    parameter int PRE_W  = 10,
    parameter int PW_W   = 6,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              step,
    input  logic              skip,
    output logic [PRE_W-1:0]  pre,
    output logic [PW_W-1:0]   post_word,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pre,
    output logic              last
);

    // step walks one word; skip jumps a whole pre row (post_word is 0 whenever skip is used)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre       <= '0;
            post_word <= '0;
            addr      <= '0;
        end else if (clr) begin
            pre       <= '0;
            post_word <= '0;
            addr      <= '0;
        end else if (skip) begin
            pre  <= pre + 1'b1;
            addr <= addr + ADDR_W'(N_PW);
        end else if (step) begin
            addr      <= addr + 1'b1;
            post_word <= (post_word == PW_W'(N_PW - 1)) ? '0 : post_word + 1'b1;
            pre       <= (post_word == PW_W'(N_PW - 1)) ? pre + 1'b1 : pre;
        end
    end

    // End-of-row and end-of-sweep flags
    always_comb begin
        last_pre = pre == PRE_W'(N_PRE - 1);
        last     = last_pre && (post_word == PW_W'(N_PW - 1));
    end

endmodule

// File: rtl/syn_update_sched.sv
// syn_update_sched: read-modify-write sequencer for the FF-STDP weight sweep with word-boundary host arbitration.
// Optional build macro SYN_UPDATE_SKIP_ZERO_PRE_EN skips pre rows whose spike count is zero via a PCHK cycle.
module syn_update_sched
    import syn_sched_pkg::*;
#(
    parameter int INPUT_NEURON         = DEF_INPUT_NEURON,
    parameter int OUTPUT_NEURON        = DEF_OUTPUT_NEURON,
    parameter int POST_NEUR_PARALLEL   = DEF_POST_NEUR_PARALLEL,
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            IS_TRAIN,
    input  logic                            UPDATE_START,
    input  logic [7:0]                      PRE_NEUR_S_CNT,
    input  logic                            HOST_REQ,
    input  logic                            HOST_WE,
    input  logic [SYN_ARRAY_ADDR_WIDTH-1:0] HOST_ADDR,
    output logic                            HOST_GNT,
    output logic                            CTRL_SYNARRAY_CS,
    output logic                            CTRL_SYNARRAY_WE,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
    output logic                            CTRL_GRAD_ARRAY_CS,
    output logic                            CTRL_GRAD_ARRAY_WE,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
    output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
    output logic                            CTRL_TREF_EVENT,
    output logic                            UPDATE_BUSY,
    output logic                            UPDATE_DONE
);

    localparam int N_PW = OUTPUT_NEURON / POST_NEUR_PARALLEL;
    localparam int PW_W = idx_width(N_PW);
`ifdef SYN_UPDATE_SKIP_ZERO_PRE_EN
    localparam state_t ENTRY = PCHK;
`else
    localparam state_t ENTRY = RD;
`endif

    state_t                          state;
    state_t                          wr_next;
    logic                            done_q;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre;
    logic [PW_W-1:0]                 post_word;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0] addr;
    logic                            last_pre;
    logic                            last_word;
    logic                            start;
    logic                            sweep_rd;
    logic                            wr;
    logic                            pchk_zero;
    logic                            fin;
    logic                            clr;
    logic                            step;
    logic                            skip;

    syn_addr_gen #(
        .N_PRE  (INPUT_NEURON),
        .N_PW   (N_PW),
        .PRE_W  (PRE_NEUR_ADDR_WIDTH),
        .PW_W   (PW_W),
        .ADDR_W (SYN_ARRAY_ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (CLK),
        .rst_n     (RST_N),
        .clr       (clr),
        .step      (step),
        .skip      (skip),
        .pre       (pre),
        .post_word (post_word),
        .addr      (addr),
        .last_pre  (last_pre),
        .last      (last_word)
    );

    // Sweep control decode; counters are cleared at start and at sweep end so IDLE shows index 0
    always_comb begin
        start    = (state == IDLE) && UPDATE_START && IS_TRAIN;
        sweep_rd = (state == RD) && !HOST_REQ;
        wr       = state == WR;
`ifdef SYN_UPDATE_SKIP_ZERO_PRE_EN
        pchk_zero = (state == PCHK) && !HOST_REQ && (PRE_NEUR_S_CNT == 8'd0);
        wr_next   = (post_word == PW_W'(N_PW - 1)) ? PCHK : RD;
`else
        pchk_zero = 1'b0;
        wr_next   = RD;
`endif
        fin  = (wr && last_word) || (pchk_zero && last_pre);
        clr  = start || fin;
        step = wr && !last_word;
        skip = pchk_zero && !last_pre;
    end

    // Sweep FSM; UPDATE_DONE is registered so it lands in the first IDLE cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= fin;
            case (state)
                IDLE: if (start) state <= ENTRY;
                RD:   if (!HOST_REQ) state <= WR;
                WR:   state <= last_word ? IDLE : wr_next;
`ifdef SYN_UPDATE_SKIP_ZERO_PRE_EN
                PCHK: if (!HOST_REQ) state <= (PRE_NEUR_S_CNT != 8'd0) ? RD : (last_pre ? IDLE : PCHK);
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM and status outputs; the host may take any cycle except the write-back half of a word
    always_comb begin
        HOST_GNT                 = HOST_REQ && (state != WR);
        CTRL_SYNARRAY_CS         = HOST_GNT || sweep_rd || wr;
        CTRL_SYNARRAY_WE         = HOST_GNT ? HOST_WE : wr;
        CTRL_SYNARRAY_ADDR       = HOST_GNT ? HOST_ADDR : addr;
        CTRL_GRAD_ARRAY_CS       = sweep_rd || wr;
        CTRL_GRAD_ARRAY_WE       = wr;
        CTRL_TREF_EVENT          = wr;
        CTRL_PRE_NEURON_ADDRESS  = pre;
        CTRL_POST_NEURON_ADDRESS = POST_NEUR_ADDR_WIDTH'(int'(post_word) * POST_NEUR_PARALLEL);
        UPDATE_BUSY              = state != IDLE;
        UPDATE_DONE              = done_q;
    end

`ifndef SYN_UPDATE_SKIP_ZERO_PRE_EN
    logic unused_s_cnt;
    assign unused_s_cnt = ^PRE_NEUR_S_CNT;
`endif

endmodule

// File: tb/tb_syn_update_sched.sv
// tb_syn_update_sched: directed bench with a word-level sweep model checked every cycle.
module tb_syn_update_sched;

    localparam int N_PRE = 20;
    localparam int PW    = 64;
    localparam int PAR   = 4;
    localparam int DEPTH = N_PRE * PW;
`ifdef SYN_UPDATE_SKIP_ZERO_PRE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        CLK, RST_N, IS_TRAIN, UPDATE_START, HOST_REQ, HOST_WE;
    logic [7:0]  PRE_NEUR_S_CNT;
    logic [15:0] HOST_ADDR;
    logic        HOST_GNT, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_GRAD_ARRAY_CS, CTRL_GRAD_ARRAY_WE;
    logic [15:0] CTRL_SYNARRAY_ADDR;
    logic [9:0]  CTRL_PRE_NEURON_ADDRESS, CTRL_POST_NEURON_ADDRESS;
    logic        CTRL_TREF_EVENT, UPDATE_BUSY, UPDATE_DONE;

    bit only5;
    int n_chk, n_fail, cyc, first_rd_cyc, done_cyc, wr_cnt, first_wr, last_wr;
    int m_ph, m_idx;
    bit m_done;

    syn_update_sched #(.INPUT_NEURON(N_PRE)) dut (
        .CLK(CLK), .RST_N(RST_N), .IS_TRAIN(IS_TRAIN), .UPDATE_START(UPDATE_START),
        .PRE_NEUR_S_CNT(PRE_NEUR_S_CNT), .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
        .HOST_GNT(HOST_GNT), .CTRL_SYNARRAY_CS(CTRL_SYNARRAY_CS), .CTRL_SYNARRAY_WE(CTRL_SYNARRAY_WE),
        .CTRL_SYNARRAY_ADDR(CTRL_SYNARRAY_ADDR), .CTRL_GRAD_ARRAY_CS(CTRL_GRAD_ARRAY_CS),
        .CTRL_GRAD_ARRAY_WE(CTRL_GRAD_ARRAY_WE), .CTRL_PRE_NEURON_ADDRESS(CTRL_PRE_NEURON_ADDRESS),
        .CTRL_POST_NEURON_ADDRESS(CTRL_POST_NEURON_ADDRESS), .CTRL_TREF_EVENT(CTRL_TREF_EVENT),
        .UPDATE_BUSY(UPDATE_BUSY), .UPDATE_DONE(UPDATE_DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign PRE_NEUR_S_CNT = (!only5 || CTRL_PRE_NEURON_ADDRESS == 10'd5) ? 8'd3 : 8'd0;

    function automatic int cnt_of(input int p);
        return (!only5 || p == 5) ? 3 : 0;
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({HOST_GNT, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_GRAD_ARRAY_CS,
                    CTRL_GRAD_ARRAY_WE, CTRL_PRE_NEURON_ADDRESS, CTRL_POST_NEURON_ADDRESS,
                    CTRL_TREF_EVENT, UPDATE_BUSY, UPDATE_DONE});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Word-level model: phase 0 idle, 1 read, 2 write-back, 3 spike-count check
    always @(negedge CLK) begin : cmp
        logic e_gnt, e_rd, e_wr;
        cyc++;
        if (!RST_N) begin
            m_ph = 0; m_idx = 0; m_done = 1'b0;
        end
        e_gnt = HOST_REQ && m_ph != 2;
        e_rd  = m_ph == 1 && !HOST_REQ;
        e_wr  = m_ph == 2;
        chk("ctrl", 64'({HOST_GNT, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_GRAD_ARRAY_CS,
                         CTRL_GRAD_ARRAY_WE, CTRL_TREF_EVENT, UPDATE_BUSY, UPDATE_DONE}),
                    64'({e_gnt, e_gnt || e_rd || e_wr, e_gnt ? HOST_WE : e_wr, e_rd || e_wr,
                         e_wr, e_wr, m_ph != 0, m_done}));
        if (e_gnt || e_rd || e_wr)
            chk("addr", 64'(CTRL_SYNARRAY_ADDR), e_gnt ? 64'(HOST_ADDR) : 64'(m_idx));
        if (m_ph != 0)
            chk("neuron", 64'({CTRL_PRE_NEURON_ADDRESS, CTRL_POST_NEURON_ADDRESS}),
                64'({10'(m_idx / PW), 10'((m_idx % PW) * PAR)}));
        if (CTRL_GRAD_ARRAY_CS && !CTRL_GRAD_ARRAY_WE && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (CTRL_TREF_EVENT) begin
            if (wr_cnt == 0) first_wr = int'(CTRL_SYNARRAY_ADDR);
            last_wr = int'(CTRL_SYNARRAY_ADDR);
            wr_cnt++;
            if (CTRL_SYNARRAY_ADDR == 16'd64) begin
                chk("addr64_pre", 64'(CTRL_PRE_NEURON_ADDRESS), 64'd1);
                chk("addr64_post", 64'(CTRL_POST_NEURON_ADDRESS), 64'd0);
            end
        end
        if (UPDATE_DONE) done_cyc = cyc;
        if (RST_N) begin
            m_done = 1'b0;
            case (m_ph)
                0: if (UPDATE_START && IS_TRAIN) begin m_idx = 0; m_ph = SKIP ? 3 : 1; end
                1: if (!HOST_REQ) m_ph = 2;
                2: if (m_idx == DEPTH - 1) begin
                       m_ph = 0; m_idx = 0; m_done = 1'b1;
                   end else begin
                       m_idx++;
                       m_ph = (SKIP && m_idx % PW == 0) ? 3 : 1;
                   end
                3: if (!HOST_REQ) begin
                       if (cnt_of(m_idx / PW) != 0) m_ph = 1;
                       else if (m_idx / PW == N_PRE - 1) begin m_ph = 0; m_idx = 0; m_done = 1'b1; end
                       else m_idx += PW;
                   end
                default: ;
            endcase
        end
    end

    task automatic clear_stats();
        first_rd_cyc = -1; done_cyc = -1; wr_cnt = 0; first_wr = -1; last_wr = -1;
    endtask

    task automatic start_pulse();
        @(posedge CLK); #1 IS_TRAIN = 1'b1; UPDATE_START = 1'b1;
        @(posedge CLK); #1 UPDATE_START = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge CLK);
            ok = UPDATE_DONE;
        end
        #1 chk("done_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_tref(input int a, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge CLK);
            ok = CTRL_TREF_EVENT && (a < 0 || int'(CTRL_SYNARRAY_ADDR) == a);
        end
        chk("tref_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        bit bad;
        n_chk = 0; n_fail = 0; cyc = 0; only5 = 1'b0;
        clear_stats();
        RST_N = 1'b0; IS_TRAIN = 1'b0; UPDATE_START = 1'b0;
        HOST_REQ = 1'b0; HOST_WE = 1'b0; HOST_ADDR = '0;
        repeat (3) @(posedge CLK);
        #1 chk("reset_outs", all_outs(), 64'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1 UPDATE_START = 1'b1;
        @(posedge CLK); #1 UPDATE_START = 1'b0;
        repeat (3) @(posedge CLK);
        #1 chk("no_train_busy", 64'(UPDATE_BUSY), 64'd0);
        HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_ADDR = 16'h0123;
        #1 chk("idle_host_gnt", 64'({HOST_GNT, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_GRAD_ARRAY_CS}), 64'b1100);
        chk("idle_host_addr", 64'(CTRL_SYNARRAY_ADDR), 64'h0123);
        @(posedge CLK); #1 HOST_REQ = 1'b0;
        clear_stats();
        start_pulse();
        wait_done(3000);
        chk("sweep_len", 64'(done_cyc - first_rd_cyc), SKIP ? 64'd2579 : 64'd2560);
        chk("wr_count", 64'(wr_cnt), 64'd1280);
        chk("first_wr", 64'(first_wr), 64'd0);
        chk("last_wr", 64'(last_wr), 64'd1279);
        clear_stats();
        start_pulse();
        wait_tref(10, 100);
        #1 HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 16'hBEEF;
        #1 chk("no_split", 64'({HOST_GNT, CTRL_TREF_EVENT}), 64'b01);
        @(negedge CLK); #1 chk("gnt_after_wr", 64'({HOST_GNT, CTRL_TREF_EVENT, CTRL_GRAD_ARRAY_CS, CTRL_SYNARRAY_WE}), 64'b1001);
        repeat (2) @(posedge CLK);
        #1 HOST_REQ = 1'b0;
        wait_tref(-1, 10);
        chk("resume_addr", 64'(CTRL_SYNARRAY_ADDR), 64'd11);
        start_pulse();
        wait_done(3000);
        clear_stats();
        start_pulse();
        wait_tref(1000, 3000);
        #2 RST_N = 1'b0;
        #1 chk("reset_async", all_outs(), 64'd0);
        @(negedge CLK);
        @(posedge CLK); #1 RST_N = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (UPDATE_DONE || UPDATE_BUSY) bad = 1'b1;
        end
        chk("no_done_after_reset", 64'(bad), 64'd0);
        clear_stats();
        start_pulse();
        wait_tref(-1, 50);
        chk("restart_addr", 64'(CTRL_SYNARRAY_ADDR), 64'd0);
        wait_done(3000);
`ifdef SYN_UPDATE_SKIP_ZERO_PRE_EN
        only5 = 1'b1;
        clear_stats();
        start_pulse();
        wait_done(1000);
        chk("skip_wr_count", 64'(wr_cnt), 64'd64);
        chk("skip_first_wr", 64'(first_wr), 64'd320);
        chk("skip_last_wr", 64'(last_wr), 64'd383);
        chk("skip_len", 64'(done_cyc - first_rd_cyc), 64'd142);
        only5 = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_update_sched.md
Name: syn_update_sched

Overview:
- Sequences the synaptic and gradient SRAMs of synaptic_core through a full FF-STDP weight-update sweep.
- Per word it does a read-modify-write: a read cycle, then a write-back cycle in which ffstdp_update's combinational result is written.
- Arbitrates a host/AER read-write requester onto the same single-port arrays, at word boundaries only.
- Sits between the top-level controller and synaptic_core; drives its CTRL_* inputs.

Parameters:
- INPUT_NEURON, 784, number of pre-synaptic neurons
- OUTPUT_NEURON, 256, number of post-synaptic neurons
- POST_NEUR_PARALLEL, 4, post neurons packed per SRAM word
- PRE_NEUR_ADDR_WIDTH, 10, pre-neuron index width
- POST_NEUR_ADDR_WIDTH, 10, post-neuron index width
- SYN_ARRAY_ADDR_WIDTH, 16, synaptic/gradient word address width

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- IS_TRAIN  in  1  training mode; sweeps are only accepted when 1
- UPDATE_START  in  1  single-cycle pulse requesting a sweep
- PRE_NEUR_S_CNT  in  8  spike count of the pre neuron at CTRL_PRE_NEURON_ADDRESS, valid one cycle after the address changes
- HOST_REQ  in  1  host access request, held until granted
- HOST_WE  in  1  host write (1) or read (0)
- HOST_ADDR  in  SYN_ARRAY_ADDR_WIDTH  host word address
- HOST_GNT  out  1  host access issued this cycle
- CTRL_SYNARRAY_CS  out  1  synaptic SRAM chip select
- CTRL_SYNARRAY_WE  out  1  synaptic SRAM write enable
- CTRL_SYNARRAY_ADDR  out  SYN_ARRAY_ADDR_WIDTH  synaptic/gradient word address
- CTRL_GRAD_ARRAY_CS  out  1  gradient SRAM chip select
- CTRL_GRAD_ARRAY_WE  out  1  gradient SRAM write enable
- CTRL_PRE_NEURON_ADDRESS  out  PRE_NEUR_ADDR_WIDTH  current pre index
- CTRL_POST_NEURON_ADDRESS  out  POST_NEUR_ADDR_WIDTH  base post index of the current word (post_word*POST_NEUR_PARALLEL)
- CTRL_TREF_EVENT  out  1  update strobe to ffstdp_update; high in write-back cycles only
- UPDATE_BUSY  out  1  sweep in progress
- UPDATE_DONE  out  1  single-cycle pulse at sweep end

Behaviour:
- Derived constants:
  - POST_WORDS = OUTPUT_NEURON/POST_NEUR_PARALLEL = 64
  - DEPTH = INPUT_NEURON*POST_WORDS = 50176
- Word address = pre*POST_WORDS + post_word. It is held as an incrementing counter; no multiplier.
- Reset: all outputs 0, FSM in IDLE, counters 0. Asserting RST_N low mid-sweep aborts the sweep; no UPDATE_DONE is issued.
- FSM states: IDLE, RD, WR (plus PCHK with the optional feature).
- IDLE:
  - UPDATE_START && IS_TRAIN -> RD with counters cleared and UPDATE_BUSY=1 from the next cycle.
  - UPDATE_START while busy or while IS_TRAIN=0 is ignored.
- RD:
  - If HOST_REQ=1, the host owns the cycle and the FSM stays in RD.
  - Otherwise drive both CS=1, both WE=0, ADDR=word address -> WR.
- WR: both CS=1, both WE=1, same ADDR, CTRL_TREF_EVENT=1. Then advance:
  - post_word < POST_WORDS-1: post_word+1, address+1 -> RD.
  - Else: post_word=0, pre+1, address+1 -> RD.
  - At pre=INPUT_NEURON-1 and post_word=POST_WORDS-1: -> IDLE, UPDATE_DONE=1 for that one cycle, UPDATE_BUSY drops in the same cycle.
- Host arbitration:
  - Grants occur only in IDLE or RD, never between the RD and WR of one word.
  - A granted cycle drives HOST_GNT=1, CTRL_SYNARRAY_CS=1, CTRL_SYNARRAY_WE=HOST_WE, ADDR=HOST_ADDR.
  - The gradient array is not selected during host cycles.
  - Host has priority over the sweep. The requester must not hold HOST_REQ indefinitely during a sweep.
- Host read data appears on SYNARRAY_RDATA one cycle after HOST_GNT.
- Nominal sweep length with no host traffic: 2*DEPTH = 100352 cycles from the first RD to UPDATE_DONE.
- All outputs are combinational from registered state and counters. There are no other combinational input-to-output paths except HOST_REQ/HOST_WE/HOST_ADDR -> HOST_GNT and the SRAM controls.

Optional Feature:
- Macro: SYN_UPDATE_SKIP_ZERO_PRE_EN.
- Defined:
  - On entering each pre neuron (post_word=0), the FSM spends one PCHK cycle sampling PRE_NEUR_S_CNT. No SRAM access occurs in PCHK.
  - If the count is 0: pre+1, address+POST_WORDS, and stay in PCHK for the next pre neuron; the last pre neuron goes to IDLE with UPDATE_DONE.
  - If the count is nonzero: -> RD.
  - Host grants are also allowed in PCHK.
- Undefined: no PCHK state; every word is visited.

Decomposition:
- Package syn_sched_pkg: state enum, POST_WORDS, DEPTH, and last-index constants.
- Sub-module syn_addr_gen: nested pre/post_word counters plus linear address counter, with clear, step and skip-row inputs and a last flag.

Test Plan:
- Reset held, then released -> all outputs 0; UPDATE_START while IS_TRAIN=0 -> UPDATE_BUSY stays 0.
- Full sweep with no host traffic -> 50176 WR cycles and addresses 0..50175 in order. At address 64, CTRL_PRE_NEURON_ADDRESS=1 and CTRL_POST_NEURON_ADDRESS=0. UPDATE_DONE occurs 100352 cycles after the first RD.
- HOST_REQ asserted during a WR cycle -> grant in the next (RD) cycle; the WR pair is never split; the sweep resumes at the same address afterwards.
- Host read at address 0x0123 in IDLE -> HOST_GNT=1, SYNARRAY CS=1, WE=0, ADDR=0x0123, grad CS=0.
- RST_N pulsed low at address 1000 -> outputs 0 immediately, no UPDATE_DONE; a new UPDATE_START restarts at address 0.
- With SYN_UPDATE_SKIP_ZERO_PRE_EN and PRE_NEUR_S_CNT=0 for all pre except 5 -> only addresses 320..383 are written; UPDATE_DONE follows.
